// File: rtl/cache_pkg.sv
// Shared cache definitions: bus widths, line-address helper and the refill engine state encoding.
package cache_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        WB_GAP,
        FILL_REQ,
        FILL_GAP,
        DONE
    } state_t;

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr,
                                                    input int line_words);
        logic [ADDR_W-1:0] mask;
        mask = ADDR_W'(line_words * WORD_BYTES - 1);
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/line_refill_master.sv
// Memory-side miss engine: optional dirty-victim writeback, then a critical-word-first
// wrapping line refill, one registered request/ack beat at a time.
module line_refill_master
    import cache_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          miss_valid,
    output logic                          miss_ready,
    input  logic [ADDR_W-1:0]             miss_addr,
    input  logic                          victim_dirty,
    input  logic [ADDR_W-1:0]             victim_addr,
    output logic [$clog2(LINE_WORDS)-1:0] wb_idx,
    input  logic [DATA_W-1:0]             wb_data,
    output logic                          fill_we,
    output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
    output logic [DATA_W-1:0]             fill_data,
    output logic                          done,
    output logic                          err,
    output logic [ADDR_W-1:0]             mem_address,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_data_out,
    input  logic                          mem_ready
);

    localparam int IDX_W  = $clog2(LINE_WORDS);
    localparam int TCNT_W = $clog2(TIMEOUT) + 1;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   beat, beat_nxt;
    logic [TCNT_W-1:0]  tcnt, tcnt_nxt;
    logic               timeout;
    logic [ADDR_W-1:0]  miss_q, victim_q;

    logic [IDX_W-1:0]   crit, fill_cur, issue_idx;
    logic [ADDR_W-1:0]  issue_src;
    logic               issue, last_beat;

    logic               miss_ready_nxt, mem_read_nxt, mem_write_nxt;
    logic               fill_we_nxt, done_nxt, err_nxt;
    logic [IDX_W-1:0]   wb_idx_nxt, fill_idx_nxt;
    logic [ADDR_W-1:0]  mem_address_nxt;
    logic [DATA_W-1:0]  mem_wdata_nxt, fill_data_nxt;

    // While idle the addresses come straight from the ports so the first request can go out on accept.
    assign crit      = (state == IDLE) ? miss_addr[2 +: IDX_W] : miss_q[2 +: IDX_W];
    assign fill_cur  = crit + beat;
    assign last_beat = (beat == IDX_W'(LINE_WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            beat        <= '0;
            tcnt        <= '0;
            miss_q      <= '0;
            victim_q    <= '0;
            miss_ready  <= 1'b1;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            wb_idx      <= '0;
            fill_we     <= 1'b0;
            fill_idx    <= '0;
            fill_data   <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            beat        <= beat_nxt;
            tcnt        <= tcnt_nxt;
            if (state == IDLE && miss_valid) begin
                miss_q   <= miss_addr;
                victim_q <= victim_addr;
            end
            miss_ready  <= miss_ready_nxt;
            mem_read    <= mem_read_nxt;
            mem_write   <= mem_write_nxt;
            mem_address <= mem_address_nxt;
            mem_wdata   <= mem_wdata_nxt;
            wb_idx      <= wb_idx_nxt;
            fill_we     <= fill_we_nxt;
            fill_idx    <= fill_idx_nxt;
            fill_data   <= fill_data_nxt;
            done        <= done_nxt;
            err         <= err_nxt;
        end
    end

    // A new beat is only launched from a GAP state once mem_ready has fallen.
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        tcnt_nxt  = tcnt;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (miss_valid) begin
                    state_nxt = victim_dirty ? WB_REQ : FILL_REQ;
                    beat_nxt  = '0;
                    tcnt_nxt  = '0;
                end
            end
            WB_REQ, FILL_REQ: begin
                if (mem_ready) begin
                    state_nxt = (state == WB_REQ) ? WB_GAP : FILL_GAP;
                end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                    state_nxt = DONE;
                    timeout   = 1'b1;
                end else begin
                    tcnt_nxt = tcnt + TCNT_W'(1);
                end
            end
            WB_GAP: begin
                if (!mem_ready) begin
                    tcnt_nxt  = '0;
                    state_nxt = last_beat ? FILL_REQ : WB_REQ;
                    beat_nxt  = last_beat ? '0 : beat + IDX_W'(1);
                end
            end
            FILL_GAP: begin
                if (!mem_ready) begin
                    tcnt_nxt  = '0;
                    state_nxt = last_beat ? DONE : FILL_REQ;
                    beat_nxt  = last_beat ? beat : beat + IDX_W'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs are the next-cycle view of the FSM.
    always_comb begin
        issue     = (state_nxt == WB_REQ || state_nxt == FILL_REQ) && (state_nxt != state);
        issue_idx = (state_nxt == WB_REQ) ? beat_nxt : crit + beat_nxt;
        if (state_nxt == WB_REQ) begin
            issue_src = (state == IDLE) ? victim_addr : victim_q;
        end else begin
            issue_src = (state == IDLE) ? miss_addr : miss_q;
        end

        miss_ready_nxt  = (state_nxt == IDLE);
        mem_read_nxt    = (state_nxt == FILL_REQ);
        mem_write_nxt   = (state_nxt == WB_REQ);
        mem_address_nxt = mem_address;
        mem_wdata_nxt   = mem_wdata;
        if (issue) begin
            mem_address_nxt = line_base(issue_src, LINE_WORDS) + ADDR_W'({issue_idx, 2'b00});
            if (state_nxt == WB_REQ) begin
                mem_wdata_nxt = wb_data;
            end
        end

        // wb_idx runs one beat ahead so wb_data is already valid when the next write is raised.
        wb_idx_nxt = wb_idx;
        if (state == WB_REQ && mem_ready) begin
            wb_idx_nxt = wb_idx + IDX_W'(1);
        end else if (state_nxt != WB_REQ && state_nxt != WB_GAP) begin
            wb_idx_nxt = '0;
        end

        fill_we_nxt   = (state == FILL_REQ) && mem_ready;
        fill_idx_nxt  = fill_we_nxt ? fill_cur : fill_idx;
        fill_data_nxt = fill_we_nxt ? mem_data_out : fill_data;
        done_nxt      = (state_nxt == DONE);
        err_nxt       = timeout;
    end

endmodule

// File: tb/tb_line_refill_master.sv
// Scoreboard bench for line_refill_master: directed misses against a single-port memory model.
module tb_line_refill_master;

    localparam int LW = 4;
    localparam int TO = 64;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] data;
    } fill_t;

    logic        clk;
    logic        rst;
    logic        miss_valid;
    logic        miss_ready;
    logic [31:0] miss_addr;
    logic        victim_dirty;
    logic [31:0] victim_addr;
    logic [1:0]  wb_idx;
    logic [31:0] wb_data;
    logic        fill_we;
    logic [1:0]  fill_idx;
    logic [31:0] fill_data;
    logic        done;
    logic        err;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_data_out;
    logic        mem_ready;
    logic        stall;

    logic [31:0] cache [LW];
    bit          mem_wr_valid [1024];
    logic [31:0] mem_store [1024];

    logic [31:0] exp_reads[$];
    wr_t         exp_writes[$];
    fill_t       exp_fills[$];
    bit          exp_done[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rise = -1;
    int done_seen = 0;
    bit prev_req = 0;
    bit prev_done = 0;
    bit prev_accept = 0;

    line_refill_master #(.LINE_WORDS(LW), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .miss_valid   (miss_valid),
        .miss_ready   (miss_ready),
        .miss_addr    (miss_addr),
        .victim_dirty (victim_dirty),
        .victim_addr  (victim_addr),
        .wb_idx       (wb_idx),
        .wb_data      (wb_data),
        .fill_we      (fill_we),
        .fill_idx     (fill_idx),
        .fill_data    (fill_data),
        .done         (done),
        .err          (err),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_data_out (mem_data_out),
        .mem_ready    (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign wb_data = cache[wb_idx];

    // Unwritten memory words read back as 0xC0DE0000 | byte address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        int i;
        i = int'(a[11:2]);
        return mem_wr_valid[i] ? mem_store[i] : (32'hC0DE_0000 | {20'b0, a[11:2], 2'b00});
    endfunction

    // Memory acks one cycle after sampling a request, for exactly one cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_ready    <= 1'b0;
            mem_data_out <= '0;
        end else if (!stall && (mem_read || mem_write) && !mem_ready) begin
            mem_ready <= 1'b1;
            if (mem_write) begin
                mem_store[mem_address[11:2]]    <= mem_wdata;
                mem_wr_valid[mem_address[11:2]] <= 1'b1;
            end else begin
                mem_data_out <= memWord(mem_address);
            end
        end else begin
            mem_ready <= 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a request, fill or done.
    always @(negedge clk) begin
        if (rst) begin
            prev_req    = 0;
            prev_done   = 0;
            prev_accept = 0;
        end else begin
            cyc++;
            if (mem_read || mem_write)
                checkOutput("rw_exclusive", {31'b0, mem_read & mem_write}, 32'h0);
            if ((mem_read || mem_write) && !prev_req) begin
                checkOutput("req_while_ready", {31'b0, mem_ready}, 32'h0);
                if (last_rise >= 0) begin
                    checks++;
                    if (cyc - last_rise < 3) begin
                        errors++;
                        $display("[TB] FAIL beat_cycles: got %0d, required >= 3", cyc - last_rise);
                    end
                end
                last_rise = cyc;
                if (mem_read) begin
                    if (exp_reads.size() == 0) checkOutput("unexpected_read", mem_address, 32'hFFFF_FFFF);
                    else checkOutput("read_addr", mem_address, exp_reads.pop_front());
                end
                if (mem_write) begin
                    if (exp_writes.size() == 0) begin
                        checkOutput("unexpected_write", mem_address, 32'hFFFF_FFFF);
                    end else begin
                        wr_t w;
                        w = exp_writes.pop_front();
                        checkOutput("write_addr", mem_address, w.addr);
                        checkOutput("write_data", mem_wdata, w.data);
                    end
                end
            end
            if (fill_we) begin
                if (exp_fills.size() == 0) begin
                    checkOutput("unexpected_fill", {30'b0, fill_idx}, 32'hFFFF_FFFF);
                end else begin
                    fill_t f;
                    f = exp_fills.pop_front();
                    checkOutput("fill_idx", {30'b0, fill_idx}, {30'b0, f.idx});
                    checkOutput("fill_data", fill_data, f.data);
                end
            end
            if (err)
                checkOutput("err_with_done", {31'b0, done}, 32'h1);
            if (done) begin
                done_seen++;
                checkOutput("ready_during_done", {31'b0, miss_ready}, 32'h0);
                if (exp_done.size() == 0) checkOutput("unexpected_done", {31'b0, err}, 32'hFFFF_FFFF);
                else checkOutput("done_err", {31'b0, err}, {31'b0, exp_done.pop_front()});
            end
            if (prev_done)
                checkOutput("ready_after_done", {31'b0, miss_ready}, 32'h1);
            if (prev_accept)
                checkOutput("ready_drop", {31'b0, miss_ready}, 32'h0);
            prev_accept = miss_valid && miss_ready;
            if (prev_accept) last_rise = -1;
            prev_req  = mem_read || mem_write;
            prev_done = done;
        end
    end

    task automatic applyStimulus(input logic [31:0] addr, input logic dirty,
                                 input logic [31:0] vaddr, input bit hold);
        int n;
        n = 0;
        @(negedge clk);
        miss_valid   = 1'b1;
        miss_addr    = addr;
        victim_dirty = dirty;
        victim_addr  = vaddr;
        while (!miss_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!miss_ready) checkOutput("accept_timeout", {31'b0, miss_ready}, 32'h1);
        @(negedge clk);
        if (!hold) miss_valid = 1'b0;
    endtask

    task automatic waitDone(input int target);
        int n;
        n = 0;
        while (done_seen < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (done_seen < target) checkOutput("done_wait_expired", done_seen, target);
    endtask

    task automatic pushFill(input logic [1:0] idx, input logic [31:0] addr);
        exp_reads.push_back(addr);
        exp_fills.push_back('{idx: idx, data: 32'hC0DE_0000 | addr});
    endtask

    initial begin
        int d0;
        int len;
        int seen;
        rst          = 1'b1;
        stall        = 1'b0;
        miss_valid   = 1'b0;
        miss_addr    = '0;
        victim_dirty = 1'b0;
        victim_addr  = '0;
        for (int i = 0; i < LW; i++) cache[i] = 32'hA0 + i;

        #3;
        checkOutput("reset_miss_ready", {31'b0, miss_ready}, 32'h1);
        checkOutput("reset_mem_read", {31'b0, mem_read}, 32'h0);
        checkOutput("reset_mem_address", mem_address, 32'h0);
        checkOutput("reset_wb_idx", {30'b0, wb_idx}, 32'h0);
        checkOutput("reset_done", {31'b0, done}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        $display("[TB] clean miss at 0x108");
        pushFill(2'd2, 32'h108);
        pushFill(2'd3, 32'h10C);
        pushFill(2'd0, 32'h100);
        pushFill(2'd1, 32'h104);
        exp_done.push_back(1'b0);
        applyStimulus(32'h108, 1'b0, 32'h0, 0);
        waitDone(1);

        $display("[TB] dirty miss, victim 0x2F4, miss 0x404");
        checkOutput("mem_pre_2F0", memWord(32'h2F0), 32'hC0DE_02F0);
        exp_writes.push_back('{addr: 32'h2F0, data: 32'hA0});
        exp_writes.push_back('{addr: 32'h2F4, data: 32'hA1});
        exp_writes.push_back('{addr: 32'h2F8, data: 32'hA2});
        exp_writes.push_back('{addr: 32'h2FC, data: 32'hA3});
        pushFill(2'd1, 32'h404);
        pushFill(2'd2, 32'h408);
        pushFill(2'd3, 32'h40C);
        pushFill(2'd0, 32'h400);
        exp_done.push_back(1'b0);
        applyStimulus(32'h404, 1'b1, 32'h2F4, 0);
        waitDone(2);
        checkOutput("mem_2F0", memWord(32'h2F0), 32'hA0);
        checkOutput("mem_2F4", memWord(32'h2F4), 32'hA1);
        checkOutput("mem_2F8", memWord(32'h2F8), 32'hA2);
        checkOutput("mem_2FC", memWord(32'h2FC), 32'hA3);

        $display("[TB] timeout with memory stalled");
        stall = 1'b1;
        exp_reads.push_back(32'h500);
        exp_done.push_back(1'b1);
        applyStimulus(32'h500, 1'b0, 32'h0, 0);
        len = 0;
        while (mem_read && len < 200) begin
            len++;
            @(negedge clk);
        end
        checkOutput("timeout_len", len, TO);
        waitDone(3);
        @(negedge clk);
        stall = 1'b0;

        $display("[TB] reset during fill beat 2");
        pushFill(2'd2, 32'h108);
        pushFill(2'd3, 32'h10C);
        pushFill(2'd0, 32'h100);
        pushFill(2'd1, 32'h104);
        d0 = done_seen;
        applyStimulus(32'h108, 1'b0, 32'h0, 0);
        seen = 0;
        for (int n = 0; n < 100 && seen < 2; n++) begin
            @(posedge clk);
            #1;
            if (fill_we) seen++;
        end
        checkOutput("reached_fill_gap", seen, 2);
        rst = 1'b1;
        #1;
        checkOutput("rst_mem_read", {31'b0, mem_read}, 32'h0);
        checkOutput("rst_mem_address", mem_address, 32'h0);
        checkOutput("rst_fill_we", {31'b0, fill_we}, 32'h0);
        checkOutput("rst_fill_data", fill_data, 32'h0);
        checkOutput("rst_done", {31'b0, done}, 32'h0);
        checkOutput("rst_miss_ready", {31'b0, miss_ready}, 32'h1);
        exp_reads.delete();
        exp_writes.delete();
        exp_fills.delete();
        exp_done.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("ready_after_reset", {31'b0, miss_ready}, 32'h1);
        checkOutput("no_done_on_reset", done_seen, d0);

        $display("[TB] back-to-back misses with miss_valid held");
        for (int i = 0; i < LW; i++) cache[i] = 32'hB0 + i;
        pushFill(2'd3, 32'h20C);
        pushFill(2'd0, 32'h200);
        pushFill(2'd1, 32'h204);
        pushFill(2'd2, 32'h208);
        exp_done.push_back(1'b0);
        exp_writes.push_back('{addr: 32'h140, data: 32'hB0});
        exp_writes.push_back('{addr: 32'h144, data: 32'hB1});
        exp_writes.push_back('{addr: 32'h148, data: 32'hB2});
        exp_writes.push_back('{addr: 32'h14C, data: 32'hB3});
        pushFill(2'd2, 32'h3F8);
        pushFill(2'd3, 32'h3FC);
        pushFill(2'd0, 32'h3F0);
        pushFill(2'd1, 32'h3F4);
        exp_done.push_back(1'b0);
        d0 = done_seen;
        applyStimulus(32'h20C, 1'b0, 32'h0, 1);
        applyStimulus(32'h3F8, 1'b1, 32'h148, 0);
        checkOutput("b2b_accept_after_done", done_seen, d0 + 1);
        waitDone(d0 + 2);
        checkOutput("mem_14C", memWord(32'h14C), 32'hB3);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty",
                    exp_reads.size() + exp_writes.size() + exp_fills.size() + exp_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
